// File: rtl/divider32_pkg.sv
// Shared constants and enumerations for the 32-bit RV32M-style divider.
package divider32_pkg;
   localparam int XLEN  = 32;
   localparam int STEPS = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } state_e;
endpackage

// File: rtl/subtract32.sv
// 32-bit subtractor used for the trial subtraction of each restoring step.
module subtract32 (
   input  logic [31:0] X,
   input  logic [31:0] Y,
   output logic [31:0] result
);
   assign result = X - Y;
endmodule

// File: rtl/divider32.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed fix-up afterwards,
// divide-by-zero and signed overflow resolved at accept time.
module divider32
   import divider32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] X,
   input  logic [XLEN-1:0] Y,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [XLEN:0]   r_q, r_d;
   logic [XLEN-1:0] d_q, d_d;
   logic [XLEN-1:0] q_q, q_d;
   logic [5:0]      cnt_q, cnt_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic [XLEN-1:0] result_q, result_d;

   op_e             op_in;
   logic            in_signed;
   logic [XLEN-1:0] x_mag, y_mag;
   logic            div_zero, sig_ovf;
   logic [XLEN:0]   shift_r;
   logic [XLEN-1:0] diff;
   logic            ge;
   logic [XLEN-1:0] quot_fix, rem_fix;

   assign op_in     = op_e'(op);
   assign in_signed = (op_in == OP_DIV) || (op_in == OP_REM);
   assign x_mag     = (in_signed && X[XLEN-1]) ? -X : X;
   assign y_mag     = (in_signed && Y[XLEN-1]) ? -Y : Y;
   assign div_zero  = (Y == '0);
   assign sig_ovf   = in_signed && (X == {1'b1, {(XLEN-1){1'b0}}}) && (Y == '1);

   assign shift_r = {r_q[XLEN-1:0], q_q[XLEN-1]};

   subtract32 u_sub (
      .X      (shift_r[XLEN-1:0]),
      .Y      (d_q),
      .result (diff)
   );

   // A set top bit in R would push the shifted value past 33 bits, so it always wins.
   assign ge = r_q[XLEN] | (shift_r >= {1'b0, d_q});

   assign quot_fix = qneg_q ? -q_q : q_q;
   assign rem_fix  = rneg_q ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      r_d      = r_q;
      d_d      = d_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d   = op_in;
               d_d    = y_mag;
               q_d    = x_mag;
               r_d    = '0;
               cnt_d  = '0;
               qneg_d = in_signed && (X[XLEN-1] ^ Y[XLEN-1]);
               rneg_d = in_signed && X[XLEN-1];
               if (div_zero) begin
                  result_d = op[1] ? X : '1;
                  state_d  = ST_DONE;
               end else if (sig_ovf) begin
                  result_d = op[1] ? '0 : X;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            r_d   = ge ? {1'b0, diff} : shift_r;
            q_d   = {q_q[XLEN-2:0], ge};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(STEPS - 1))
               state_d = ST_FIX;
         end
         ST_FIX: begin
            result_d = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quot_fix;
            state_d  = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_DIV;
         r_q      <= '0;
         d_q      <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         r_q      <= r_d;
         d_q      <= d_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
endmodule

// File: tb/tb_divider32.sv
// Directed scoreboard bench for divider32: driver pushes expectations, a monitor
// checks result and done timing whenever done pulses.
module tb_divider32;
   import divider32_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] X = '0;
   logic [31:0] Y = '0;
   logic        busy, done;
   logic [31:0] result;

   always #5 clk = ~clk;

   divider32 #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .X      (X),
      .Y      (Y),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] res;
      bit          special;
   } vec_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done at cycle %0d: result %h, expected no done", cyc, result);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            $display("done at cycle %0d result %h", cyc, result);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input bit special, input bit push);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      X     = x;
      Y     = y;
      @(posedge clk);
      #1;
      if (push) sb_q.push_back('{exp_res, cyc + (special ? 0 : 33)});
      start = 1'b0;
      X     = $urandom;
      Y     = $urandom;
      op    = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(input string name);
      int base;
      int n;
      base = done_cnt;
      n = 0;
      while (done_cnt == base && n < 60) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (done_cnt == base) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout_%s: no done within 60 cycles, expected one", name);
      end
   endtask

   vec_t vecs[] = '{
      '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0},
      '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0},
      '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0},
      '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0},
      '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1},
      '{2'b10, 32'd5,          32'd0,          32'd5,          1'b1},
      '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1},
      '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b1},
      '{2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1},
      '{2'b11, 32'h12345678,   32'd0,          32'h12345678,   1'b1},
      '{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0},
      '{2'b11, 32'hFFFFFFFF,   32'd10,         32'd5,          1'b0},
      '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0},
      '{2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0},
      '{2'b00, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          1'b0},
      '{2'b10, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'hFFFFFFFE,   1'b0},
      '{2'b01, 32'd0,          32'd5,          32'd0,          1'b0},
      '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0},
      '{2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0},
      '{2'b00, 32'h80000000,   32'd1,          32'h80000000,   1'b0}
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].special, 1'b1);
         wait_done($sformatf("vec%0d", i));
         repeat (3) @(negedge clk);
         check($sformatf("hold_vec%0d", i), result, vecs[i].res);
         check($sformatf("idle_busy_vec%0d", i), 32'(busy), 32'd0);
      end

      // Start while busy must be ignored; result must hold during CALC.
      issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      check("busy_in_calc", 32'(busy), 32'd1);
      check("hold_during_calc", result, vecs[vecs.size()-1].res);
      repeat (4) @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      X     = 32'd9;
      Y     = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored_start");
      repeat (40) @(negedge clk);
      check("after_ignored_start", result, 32'd14);

      // Reset mid-operation aborts without a done pulse.
      issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", result, 32'd0);
      repeat (40) @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);

      issue(2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      check("hold_zero_during_calc", result, 32'd0);
      wait_done("after_abort");

      // Reset wins over start on the same edge.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      op    = 2'b01;
      X     = 32'd50;
      Y     = 32'd5;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check("reset_over_start_busy", 32'(busy), 32'd0);
      check("reset_over_start_result", result, 32'd0);
      repeat (40) @(negedge clk);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/divider32.md
DIVIDER32 -- requirements
Module: divider32

Interface
REQ-001 The block SHALL declare parameter XLEN, default 32, meaning the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only when busy=0.
REQ-005 The block SHALL have port op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-006 The block SHALL have port X, input, 32 bits: dividend.
REQ-007 The block SHALL have port Y, input, 32 bits: divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the edge that accepts start until the edge on which done rises.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port result, output, 32 bits: quotient or remainder, as selected by op.

Function
REQ-011 The block SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch X, Y and op on that edge, set busy, and go to CALC.
- Exception: special cases (REQ-016/017) go directly to DONE instead.
REQ-013 The block SHALL convert signed operands (DIV, REM) to magnitudes at latch time and record the quotient sign (X[31]^Y[31]) and the remainder sign (X[31]).
REQ-014 In CALC, the block SHALL perform one restoring-division step per cycle for exactly 32 cycles, using a 33-bit partial remainder R, the divisor D and a 6-bit step counter:
- shift the next dividend bit into R;
- if R >= {1'b0,D}, set R = R-D and quotient bit = 1;
- otherwise leave R unchanged and set quotient bit = 0.
REQ-015 FIX SHALL last one cycle: negate the quotient and/or remainder per the recorded signs, select the output by op, and go to DONE.
REQ-016 Divide by zero (Y=0) SHALL skip CALC:
- DIV and DIVU give 32'hFFFFFFFF;
- REM and REMU give X.
REQ-017 Signed overflow (DIV/REM with X=32'h80000000, Y=32'hFFFFFFFF) SHALL skip CALC:
- DIV gives 32'h80000000;
- REM gives 0.
REQ-018 DONE SHALL last one cycle: done=1 and busy=0, then return to IDLE.
REQ-019 Latency SHALL be fixed:
- normal operations: done is high in the 34th cycle after the accepting edge;
- special cases: done is high in the cycle immediately after the accepting edge.
REQ-020 result SHALL hold its value from DONE until the next accepted start; it SHALL NOT change during CALC or FIX.
REQ-021 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a new start is accepted only from IDLE.
REQ-023 Operands SHALL be sampled only at the accepting edge; changes to X, Y or op during busy SHALL have no effect.

Reset
REQ-024 While reset=1 at a clock edge, the block SHALL enter IDLE and drive busy=0, done=0, result=0, and clear the counter and datapath registers.
REQ-025 Reset asserted mid-operation (CALC or FIX) SHALL abort the operation; done SHALL NOT pulse for the aborted request.
REQ-026 reset SHALL take priority over start on the same edge.

Structure
REQ-027 A shared package SHALL hold:
- the op encodings (DIV, DIVU, REM, REMU);
- the state enumeration;
- the constants XLEN=32 and STEPS=32.
REQ-028 The trial subtraction SHALL be done by one instance of the existing subtract32 sub-module (ports X, Y, result) for the low 32 bits.
- The R >= D decision SHALL come from a 33-bit comparison in divider32.
REQ-029 All other logic SHALL be written directly in divider32; no other sub-modules.

Verification
REQ-030 DIVU X=100, Y=7 -> result=14; REMU with the same operands -> result=2; done exactly 34 cycles after start.
REQ-031 DIV X=-7 (32'hFFFFFFF9), Y=2 -> result=32'hFFFFFFFD; REM with the same operands -> result=32'hFFFFFFFF.
REQ-032 DIVU X=5, Y=0 -> result=32'hFFFFFFFF; REM X=5, Y=0 -> result=5; both with done one cycle after start.
REQ-033 DIV X=32'h80000000, Y=32'hFFFFFFFF -> result=32'h80000000; REM with the same operands -> result=0.
REQ-034 Start DIVU 100/7, then pulse start with X=9, Y=3 at cycle 10 -> result=14 and only one done pulse.
REQ-035 Assert reset in cycle 15 of a DIVU -> busy=0, done never pulses, result=0; a following DIVU 9/3 -> result=3.
